clk_burst_ctrl: RTL

Synthesizable programmable clock-burst controller. It produces a square wave on `clk_out` from the system clock with a programmable half-period. It emits a programmed number of edges, or runs free until stopped, then signals completion. It sequences clock-like stimulus and strobe trains for downstream blocks, using a start/stop/done handshake.

---
 rtl/clk_burst_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/clk_burst_ctrl.sv
// clk_burst_ctrl
//   Programmable clock-burst generator. Drives a square wave on clk_out whose
//   level lasts hp = max(half_period,1) cycles of clk. It emits num_toggles
//   transitions and then pulses done. A stop request in RUN aborts the burst.
//
//   Optional feature macro: CLKGEN_FREE_RUN_EN
//     defined   : num_toggles==0 runs free until stop (toggles_left stays 0)
//     undefined : num_toggles==0 goes straight to DONE with no transition
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   burst request, sampled in IDLE only
//   stop          in   abort request, effective in RUN only
//   half_period   in   [CNT_W] clk cycles per clk_out level (0 treated as 1)
//   num_toggles   in   [TGL_W] clk_out transitions to emit
//   clk_out       out  generated waveform (registered)
//   busy          out  high while in RUN
//   done          out  one-cycle completion pulse (DONE state)
//   aborted       out  last burst ended through stop
//   toggles_left  out  [TGL_W] remaining transitions
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, clk_out held low
// RUN   | counting half-periods, toggling clk_out
// DONE  | one-cycle completion, clk_out holds its final level

module clk_burst_ctrl #(
    parameter int CNT_W = 16,
    parameter int TGL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] half_period,
    input  logic [TGL_W-1:0] num_toggles,
    output logic             clk_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [TGL_W-1:0] toggles_left
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp_last;
    logic             free_run;
    logic             last_toggle;

    assign hp_last     = hp - CNT_W'(1);
    assign last_toggle = (toggles_left == TGL_W'(1));

    // A burst that is still in RUN with nothing left to count can only be a
    // free-running one; a counted burst leaves RUN on its final transition.
`ifdef CLKGEN_FREE_RUN_EN
    assign free_run = (toggles_left == '0);
`else
    assign free_run = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hp           <= CNT_W'(1);
            cnt          <= '0;
            clk_out      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            toggles_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    clk_out <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        hp           <= (half_period == '0) ? CNT_W'(1) : half_period;
                        toggles_left <= num_toggles;
                        cnt          <= '0;
                        aborted      <= 1'b0;
`ifdef CLKGEN_FREE_RUN_EN
                        state <= ST_RUN;
                        busy  <= 1'b1;
`else
                        if (num_toggles == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
`endif
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        // abort wins over a toggle due on the same edge
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt == hp_last) begin
                        clk_out <= ~clk_out;
                        cnt     <= '0;
                        if (!free_run) begin
                            toggles_left <= toggles_left - TGL_W'(1);
                            if (last_toggle) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state   <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    clk_out <= 1'b0;
                end

                default: begin
                    state   <= ST_IDLE;
                    clk_out <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
